// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS weight-update engine.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package lms_pkg;

    // Sequencer states of the update engine.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCALE  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } lms_state_t;

    // Round-half-up constant added before an arithmetic right shift by sh.
    function automatic longint rnd_const(input int sh);
        if (sh <= 0) begin
            return 64'sd0;
        end
        return 64'sd1 <<< (sh - 1);
    endfunction

    // Largest two's-complement value representable in w bits.
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest two's-complement value representable in w bits.
    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Clamp bounds for the default 16-bit datapath.
    localparam int     LMS_DEF_WIDTH = 16;
    localparam longint LMS_SAT_MAX   = sat_max(LMS_DEF_WIDTH);
    localparam longint LMS_SAT_MIN   = sat_min(LMS_DEF_WIDTH);

endpackage

// File: rtl/lms_tap_update.sv
// One-tap multiply/round/shift/accumulate; also forms mu*e when i_scale=1.
// Latency: purely combinational, no pipeline stage.
// Backpressure: none; LMS_SATURATE_EN selects clamping instead of wrap.
module lms_tap_update
    import lms_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QP    = 12,
    parameter int SHIFT = 0
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_mu_e,
    input  logic [WIDTH-1:0] i_w_old,
    input  logic             i_scale,
    output logic [WIDTH-1:0] o_w_new
);

    localparam int SH_S = QP;
    localparam int SH_U = QP + SHIFT;
    localparam logic signed [2*WIDTH-1:0] RND_S = (2*WIDTH)'(rnd_const(SH_S));
    localparam logic signed [2*WIDTH-1:0] RND_U = (2*WIDTH)'(rnd_const(SH_U));

    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [2*WIDTH-1:0] w_rnd;
    logic signed [2*WIDTH-1:0] w_sh;

    // Full-precision signed product, rounded half-up, then scaled down.
    assign w_prod = $signed({{WIDTH{i_x[WIDTH-1]}}, i_x})
                  * $signed({{WIDTH{i_mu_e[WIDTH-1]}}, i_mu_e});
    assign w_rnd  = w_prod + (i_scale ? RND_S : RND_U);
    assign w_sh   = i_scale ? (w_rnd >>> SH_S) : (w_rnd >>> SH_U);

`ifdef LMS_SATURATE_EN
    localparam logic signed [2*WIDTH-1:0] SMAX = (2*WIDTH)'(sat_max(WIDTH));
    localparam logic signed [2*WIDTH-1:0] SMIN = (2*WIDTH)'(sat_min(WIDTH));
    localparam logic [WIDTH-1:0]          WMAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0]          WMIN = WIDTH'(sat_min(WIDTH));

    logic signed [2*WIDTH-1:0] w_delta;
    logic signed [2*WIDTH-1:0] w_sum;

    // In scale mode the whole shifted product is clamped (w_old is 0);
    // in update mode the delta is first taken to WIDTH bits.
    assign w_delta = i_scale ? w_sh : {{WIDTH{w_sh[WIDTH-1]}}, w_sh[WIDTH-1:0]};
    assign w_sum   = $signed({{WIDTH{i_w_old[WIDTH-1]}}, i_w_old}) + w_delta;

    // Clamp the wide sum into the WIDTH-bit two's-complement range.
    always_comb begin
        o_w_new = w_sum[WIDTH-1:0];
        if (w_sum > SMAX) begin
            o_w_new = WMAX;
        end else if (w_sum < SMIN) begin
            o_w_new = WMIN;
        end
    end
`else
    // Plain wrap: low WIDTH bits of the shifted product added to the old weight.
    assign o_w_new = i_w_old + w_sh[WIDTH-1:0];
`endif

endmodule

// File: rtl/lms_weight_update.sv
// Sequential LMS weight update w[k] += round(mu*e*x[k]) using one shared tap unit.
// Latency: start-to-done ORD+2 cycles; next start accepted ORD+3 cycles after.
// Backpressure: start ignored while busy; clear aborts. LMS_SATURATE_EN clamps.
module lms_weight_update
    import lms_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QP    = 12,
    parameter int ORD   = 64,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     error_in,
    input  logic [WIDTH-1:0]     mu_in,
    input  logic [ORD*WIDTH-1:0] x_in_packed,
    output logic [ORD*WIDTH-1:0] weight_out_packed,
    output logic                 busy,
    output logic                 done
);

    localparam int KW = (ORD > 1) ? $clog2(ORD) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(ORD - 1);

    lms_state_t           r_state;
    logic [KW-1:0]        r_k;
    logic [WIDTH-1:0]     r_mu;
    logic [WIDTH-1:0]     r_err;
    logic [WIDTH-1:0]     r_mu_e;
    logic [ORD*WIDTH-1:0] r_x;
    logic [ORD*WIDTH-1:0] r_w;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_scale;
    logic [WIDTH-1:0]     w_op_x;
    logic [WIDTH-1:0]     w_op_m;
    logic [WIDTH-1:0]     w_op_w;
    logic [WIDTH-1:0]     w_new;

    // Operand steering: SCALE forms mu*e, UPDATE forms x[k]*mu_e + w[k].
    assign w_scale = (r_state == SCALE);
    assign w_op_x  = w_scale ? r_mu  : r_x[r_k*WIDTH +: WIDTH];
    assign w_op_m  = w_scale ? r_err : r_mu_e;
    assign w_op_w  = w_scale ? '0    : r_w[r_k*WIDTH +: WIDTH];

    lms_tap_update #(
        .WIDTH (WIDTH),
        .QP    (QP),
        .SHIFT (SHIFT)
    ) u_tap (
        .i_x     (w_op_x),
        .i_mu_e  (w_op_m),
        .i_w_old (w_op_w),
        .i_scale (w_scale),
        .o_w_new (w_new)
    );

    assign weight_out_packed = r_w;
    assign busy              = r_busy;
    assign done              = r_done;

    // Update sequencer: snapshot, scale, walk taps, pulse done; clear overrides all.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_mu    <= '0;
            r_err   <= '0;
            r_mu_e  <= '0;
            r_x     <= '0;
            r_w     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (clear) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_w     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mu    <= mu_in;
                        r_err   <= error_in;
                        r_x     <= x_in_packed;
                        r_busy  <= 1'b1;
                        r_state <= SCALE;
                    end
                end
                SCALE: begin
                    r_mu_e  <= w_new;
                    r_k     <= '0;
                    r_state <= UPDATE;
                end
                UPDATE: begin
                    r_w[r_k*WIDTH +: WIDTH] <= w_new;
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lms_weight_update.sv
// Self-checking bench for lms_weight_update (WIDTH=16, QP=12, ORD=4, SHIFT=0).
// Expected weight vectors are queued at each start and compared on done.
// Honours LMS_SATURATE_EN in its reference model.
module tb_lms_weight_update;

    localparam int W   = 16;
    localparam int ORD = 4;
    localparam int LAT = ORD + 2;

    logic              clk;
    logic              rstn;
    logic              start;
    logic              clear;
    logic [W-1:0]      error_in;
    logic [W-1:0]      mu_in;
    logic [ORD*W-1:0]  x_in_packed;
    logic [ORD*W-1:0]  weight_out_packed;
    logic              busy;
    logic              done;

    int                n_chk;
    int                n_bad;
    logic [ORD*W-1:0]  sb_q[$];
    logic [ORD*W-1:0]  exp_w;
    logic [ORD*W-1:0]  sb_item;

    lms_weight_update #(
        .WIDTH (W),
        .QP    (12),
        .ORD   (ORD),
        .SHIFT (0)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .start             (start),
        .clear             (clear),
        .error_in          (error_in),
        .mu_in             (mu_in),
        .x_in_packed       (x_in_packed),
        .weight_out_packed (weight_out_packed),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint fit(input longint v);
`ifdef LMS_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        return longint'(shortint'(v));
`endif
    endfunction

    function automatic logic [ORD*W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [W-1:0] a16, b16, c16, d16;
        a16 = W'(a); b16 = W'(b); c16 = W'(c); d16 = W'(d);
        return {d16, c16, b16, a16};
    endfunction

    // Reference: mu_e = round(mu*e / 2^12), delta = round(x*mu_e / 2^12).
    function automatic logic [ORD*W-1:0] model(input logic [ORD*W-1:0] w,
                                               input logic signed [W-1:0] mu,
                                               input logic signed [W-1:0] e,
                                               input logic [ORD*W-1:0] x);
        longint me, d, s;
        logic [ORD*W-1:0] r;
        logic [W-1:0] xs, ws;
        r  = '0;
        me = fit((longint'(mu) * longint'(e) + 2048) >>> 12);
        for (int i = 0; i < ORD; i++) begin
            xs = x[W*i +: W];
            ws = w[W*i +: W];
            d = (longint'($signed(xs)) * me + 2048) >>> 12;
            d = longint'(shortint'(d));
            s = fit(longint'($signed(ws)) + d);
            r[W*i +: W] = W'(s);
        end
        return r;
    endfunction

    function automatic longint tap(input logic [ORD*W-1:0] v, input int i);
        logic [W-1:0] t;
        t = v[W*i +: W];
        return longint'($signed(t));
    endfunction

    // Scoreboard: every done pops one expected vector; an unexpected done fails.
    always @(negedge clk) begin
        if (rstn && done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", done, 0);
            end else begin
                sb_item = sb_q.pop_front();
                for (int i = 0; i < ORD; i++) begin
                    chk($sformatf("sb_w%0d", i), tap(weight_out_packed, i), tap(sb_item, i));
                end
            end
        end
    end

    task automatic do_update(input logic [W-1:0] mu, input logic [W-1:0] e,
                             input logic [ORD*W-1:0] x, input bit poke);
        int lat;
        @(negedge clk);
        mu_in = mu; error_in = e; x_in_packed = x; start = 1'b1;
        exp_w = model(exp_w, mu, e, x);
        sb_q.push_back(exp_w);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            chk("busy_run", busy, 1);
            if (poke && lat == 3) begin
                start = 1'b1; mu_in = 16'h7fff; error_in = 16'h4000;
                x_in_packed = pack4(1000, 2000, 3000, 4000);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, LAT);
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("done_low", done, 0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_w = '0;
        chk("clear_w", weight_out_packed, 0);
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        rstn = 1'b0; start = 1'b0; clear = 1'b0;
        error_in = '0; mu_in = '0; x_in_packed = '0; exp_w = '0;
        #12;
        chk("rst_w", weight_out_packed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic update, then the same again accumulating, with a start poked mid-busy.
        do_update(16'd2048, 16'd4096, pack4(4096, -4096, 2048, 0), 1'b0);
        chk("basic_vec", weight_out_packed, pack4(2048, -2048, 1024, 0));
        do_update(16'd2048, 16'd4096, pack4(4096, -4096, 2048, 0), 1'b1);
        chk("accum_vec", weight_out_packed, pack4(4096, -4096, 2048, 0));
        repeat (ORD + 4) @(negedge clk);
        chk("poke_ignored", weight_out_packed, pack4(4096, -4096, 2048, 0));

        // Round-half-up on a positive and a negative half.
        do_clear();
        do_update(16'd4096, 16'd2048, pack4(1, 0, 0, 0), 1'b0);
        chk("round_pos", tap(weight_out_packed, 0), 1);
        do_clear();
        do_update(16'd4096, 16'd2048, pack4(-1, 0, 0, 0), 1'b0);
        chk("round_neg", tap(weight_out_packed, 0), 0);

        // Overflow at the positive edge: 0x7F00 + 2048.
        do_clear();
        do_update(16'd4096, 16'd4096, pack4(32512, 5, -7, 100), 1'b0);
        chk("preload", tap(weight_out_packed, 0), 32512);
        do_update(16'd4096, 16'd4096, pack4(2048, 5, -7, 100), 1'b0);
`ifdef LMS_SATURATE_EN
        chk("ovf_w0", weight_out_packed[15:0], 16'h7fff);
`else
        chk("ovf_w0", weight_out_packed[15:0], 16'h8700);
`endif

        // Negative scale and mixed taps.
        do_update(16'hf000, 16'd3000, pack4(-1234, 777, 32767, -32768), 1'b0);

        // Clear during cycle 3 of an update: no done, weights zero.
        @(negedge clk);
        mu_in = 16'd2048; error_in = 16'd4096; x_in_packed = pack4(4096, 4096, 4096, 4096);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_w = '0;
        chk("abort_busy", busy, 0);
        chk("abort_w", weight_out_packed, 0);
        repeat (ORD + 4) @(negedge clk);
        chk("abort_w_hold", weight_out_packed, 0);

        // Clear and start together: start dropped.
        @(negedge clk);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        chk("cs_busy", busy, 0);
        repeat (ORD + 4) @(negedge clk);
        chk("cs_w", weight_out_packed, 0);

        // Asynchronous reset in the middle of an update.
        do_update(16'd4096, 16'd4096, pack4(11, 22, 33, 44), 1'b0);
        @(negedge clk);
        mu_in = 16'd4096; error_in = 16'd4096; x_in_packed = pack4(100, 200, 300, 400);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_w", weight_out_packed, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        sb_q.delete();
        exp_w = '0;
        @(negedge clk);
        rstn = 1'b1;
        do_update(16'd2048, 16'd4096, pack4(4096, -4096, 2048, 0), 1'b0);
        chk("post_rst_vec", weight_out_packed, pack4(2048, -2048, 1024, 0));

        repeat (3) @(negedge clk);
        chk("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
